// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_LDR  = 1'b1;

   function automatic logic [1:0] port_onehot(input logic idx);
      if (idx == PORT_LDR) begin
         return 2'b10;
      end else begin
         return 2'b01;
      end
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data RAM.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_ack;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_ack;
   logic [DATA_W-1:0] ldr_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter view: takes requests, drives the RAM.
   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_ack, core_rdata, core_stall,
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_ack, ldr_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_ack, core_rdata, core_stall,
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_ack, ldr_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/dmem_arbiter_pick2.sv
// Combinational two-way grant picker; DMEM_ARB_RR_EN selects round-robin,
// otherwise the core has fixed priority over the loader.
module arb_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
   // On contention the port that did not win last time gets the grant.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         if (last_grant == PORT_LDR) begin
            gnt = 2'b01;
         end else begin
            gnt = 2'b10;
         end
      end else begin
         gnt = req;
      end
   end
`else
   logic unused_s;
   assign unused_s = last_grant;

   // Core always wins on contention.
   always_comb begin
      gnt = 2'b00;
      if (req[PORT_CORE]) begin
         gnt = 2'b01;
      end else if (req[PORT_LDR]) begin
         gnt = 2'b10;
      end else begin
         gnt = 2'b00;
      end
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the core and the loader port.
// DMEM_ARB_RR_EN enables round-robin arbitration (default: core priority).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   dmem_arbiter_if.slave  bus
);

   arb_state_e        state_r;
   arb_state_e        state_s;
   logic              owner_r;
   logic [1:0]        ack_r;
   logic [1:0]        ack_s;
   logic              mem_en_r;
   logic              mem_en_s;
   logic              mem_we_r;
   logic              mem_we_s;
   logic [ADDR_W-1:0] cmd_addr_r;
   logic [DATA_W-1:0] cmd_wdata_r;

   logic [1:0]        req_s;
   logic [1:0]        gnt_s;
   logic              take_s;
   logic              gnt_port_s;
   logic              sel_we_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic [DATA_W-1:0] sel_wdata_s;
   logic              last_s;
   logic              core_ack_s;
   logic              ldr_ack_s;
   logic              resp_s;

   assign req_s       = {bus.ldr_req, bus.core_req};
   assign gnt_port_s  = gnt_s[PORT_LDR];
   assign sel_we_s    = gnt_port_s ? bus.ldr_we    : bus.core_we;
   assign sel_addr_s  = gnt_port_s ? bus.ldr_addr  : bus.core_addr;
   assign sel_wdata_s = gnt_port_s ? bus.ldr_wdata : bus.core_wdata;

`ifdef DMEM_ARB_RR_EN
   logic last_r;

   // Remembers which port won the most recent grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_r <= PORT_LDR;
      end else if (take_s) begin
         last_r <= gnt_port_s;
      end else begin
         last_r <= last_r;
      end
   end

   assign last_s = last_r;
`else
   assign last_s = PORT_LDR;
`endif

   arb_pick2 u_pick (
      .req        (req_s),
      .last_grant (last_s),
      .gnt        (gnt_s)
   );

   // Next-state and next-output decode; requests only matter in IDLE.
   always_comb begin
      state_s  = state_r;
      ack_s    = 2'b00;
      mem_en_s = 1'b0;
      mem_we_s = 1'b0;
      take_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (gnt_s != 2'b00) begin
               state_s  = ACCESS;
               take_s   = 1'b1;
               mem_en_s = 1'b1;
               mem_we_s = sel_we_s;
               if (sel_we_s) begin
                  ack_s = gnt_s;
               end else begin
                  ack_s = 2'b00;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (mem_we_r) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
               ack_s   = port_onehot(owner_r);
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, owner, latched command and registered RAM strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         owner_r     <= PORT_CORE;
         ack_r       <= 2'b00;
         mem_en_r    <= 1'b0;
         mem_we_r    <= 1'b0;
         cmd_addr_r  <= {ADDR_W{1'b0}};
         cmd_wdata_r <= {DATA_W{1'b0}};
      end else begin
         state_r  <= state_s;
         ack_r    <= ack_s;
         mem_en_r <= mem_en_s;
         mem_we_r <= mem_we_s;
         if (take_s) begin
            owner_r     <= gnt_port_s;
            cmd_addr_r  <= sel_addr_s;
            cmd_wdata_r <= sel_wdata_s;
         end else begin
            owner_r     <= owner_r;
            cmd_addr_r  <= cmd_addr_r;
            cmd_wdata_r <= cmd_wdata_r;
         end
      end
   end

   // A reset landing mid-transaction suppresses the pending acknowledge.
   assign core_ack_s = ack_r[PORT_CORE] & ~rst;
   assign ldr_ack_s  = ack_r[PORT_LDR]  & ~rst;
   assign resp_s     = (state_r == RESP) & ~rst;

   assign bus.core_ack   = core_ack_s;
   assign bus.ldr_ack    = ldr_ack_s;
   assign bus.core_stall = bus.core_req & ~core_ack_s;
   assign bus.core_rdata = (resp_s && (owner_r == PORT_CORE)) ? bus.mem_rdata : {DATA_W{1'b0}};
   assign bus.ldr_rdata  = (resp_s && (owner_r == PORT_LDR))  ? bus.mem_rdata : {DATA_W{1'b0}};

   assign bus.mem_en    = mem_en_r;
   assign bus.mem_we    = mem_we_r;
   assign bus.mem_addr  = cmd_addr_r;
   assign bus.mem_wdata = cmd_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural data RAM.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

   dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Synchronous single-port RAM, read data one cycle after the strobe.
   logic [31:0] ram [0:31];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= ram[bus.mem_addr];
      end
   end

   typedef struct {
      logic        c_req, c_we;
      logic [4:0]  c_addr;
      logic [31:0] c_wdata;
      logic        l_req, l_we;
      logic [4:0]  l_addr;
      logic [31:0] l_wdata;
      logic        e_cack;
      logic [31:0] e_crd;
      logic        e_stall, e_lack;
      logic [31:0] e_lrd;
      logic        e_en, e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t vt [24];

   function automatic vec_t mk(
      input logic cr, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
      input logic lr, input logic lw, input logic [4:0] la, input logic [31:0] ld,
      input logic ecack, input logic [31:0] ecrd, input logic estall,
      input logic elack, input logic [31:0] elrd,
      input logic een, input logic ewe, input logic [4:0] eaddr, input logic [31:0] ewd);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
      v.l_req = lr; v.l_we = lw; v.l_addr = la; v.l_wdata = ld;
      v.e_cack = ecack; v.e_crd = ecrd; v.e_stall = estall;
      v.e_lack = elack; v.e_lrd = elrd;
      v.e_en = een; v.e_we = ewe; v.e_addr = eaddr; v.e_wdata = ewd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                        input logic lr, input logic lw, input logic [4:0] la, input logic [31:0] ld);
      bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
      bus.ldr_req  = lr; bus.ldr_we  = lw; bus.ldr_addr  = la; bus.ldr_wdata  = ld;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [8:0] ec;
   logic [8:0] el;
   logic       cr_k;
   logic       lr_k;

   initial begin
      //                c: req we addr wdata        l: req we addr wdata       | cack crd stall lack lrd en we addr wdata
      vt[0]  = mk(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[1]  = mk(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
      vt[2]  = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[3]  = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
      vt[4]  = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[5]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[6]  = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd5, 32'h11111111, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[7]  = mk(1'b1, 1'b0, 5'd5, 32'h0,        1'b1, 1'b1, 5'd5, 32'h11111111, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 5'd5, 32'h11111111);
      vt[8]  = mk(1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[9]  = mk(1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd5, 32'h0);
      vt[10] = mk(1'b1, 1'b0, 5'd5, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[11] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[12] = mk(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[13] = mk(1'b1, 1'b1, 5'd7, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd3, 32'hA5A5A5A5);
      vt[14] = mk(1'b1, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[15] = mk(1'b0, 1'b1, 5'd9, 32'h12345678, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 5'd9, 32'h12345678);
      vt[16] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[17] = mk(1'b1, 1'b0, 5'd9, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[18] = mk(1'b1, 1'b0, 5'd9, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0);
      vt[19] = mk(1'b1, 1'b0, 5'd9, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[20] = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[21] = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 5'd3, 32'h0);
      vt[22] = mk(1'b1, 1'b0, 5'd3, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      vt[23] = mk(1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

      // Reset state, with core_req held to show the stall follows it.
      rst = 1'b1;
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.core_ack",   {31'h0, bus.core_ack},   32'h0);
      chk("rst.ldr_ack",    {31'h0, bus.ldr_ack},    32'h0);
      chk("rst.core_stall", {31'h0, bus.core_stall}, 32'h1);
      chk("rst.mem_en",     {31'h0, bus.mem_en},     32'h0);
      chk("rst.mem_addr",   {27'h0, bus.mem_addr},   32'h0);
      chk("rst.core_rdata", bus.core_rdata,          32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         drive(vt[i].c_req, vt[i].c_we, vt[i].c_addr, vt[i].c_wdata,
               vt[i].l_req, vt[i].l_we, vt[i].l_addr, vt[i].l_wdata);
         @(negedge clk);
         chk($sformatf("v%0d.core_ack", i),   {31'h0, bus.core_ack},   {31'h0, vt[i].e_cack});
         chk($sformatf("v%0d.core_rdata", i), bus.core_rdata,          vt[i].e_crd);
         chk($sformatf("v%0d.core_stall", i), {31'h0, bus.core_stall}, {31'h0, vt[i].e_stall});
         chk($sformatf("v%0d.ldr_ack", i),    {31'h0, bus.ldr_ack},    {31'h0, vt[i].e_lack});
         chk($sformatf("v%0d.ldr_rdata", i),  bus.ldr_rdata,           vt[i].e_lrd);
         chk($sformatf("v%0d.mem_en", i),     {31'h0, bus.mem_en},     {31'h0, vt[i].e_en});
         chk($sformatf("v%0d.mem_we", i),     {31'h0, bus.mem_we},     {31'h0, vt[i].e_we});
         if (vt[i].e_en) begin
            chk($sformatf("v%0d.mem_addr", i), {27'h0, bus.mem_addr}, {27'h0, vt[i].e_addr});
            if (vt[i].e_we) begin
               chk($sformatf("v%0d.mem_wdata", i), bus.mem_wdata, vt[i].e_wdata);
            end
         end
         next_cycle();
      end

      // Reset pulsed during RESP of a core load; the held request is re-served.
      drive(1'b1, 1'b0, 5'd5, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rr.access_en", {31'h0, bus.mem_en}, 32'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rr.resp_ack",   {31'h0, bus.core_ack}, 32'h0);
      chk("rr.resp_rdata", bus.core_rdata,        32'h0);
      chk("rr.resp_lack",  {31'h0, bus.ldr_ack},  32'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rr.post_en",    {31'h0, bus.mem_en},     32'h0);
      chk("rr.post_ack",   {31'h0, bus.core_ack},   32'h0);
      chk("rr.post_rdata", bus.core_rdata,          32'h0);
      chk("rr.post_stall", {31'h0, bus.core_stall}, 32'h1);
      next_cycle();
      @(negedge clk);
      chk("rr.retry_en",   {31'h0, bus.mem_en},   32'h1);
      chk("rr.retry_addr", {27'h0, bus.mem_addr}, 32'h5);
      chk("rr.retry_we",   {31'h0, bus.mem_we},   32'h0);
      next_cycle();
      @(negedge clk);
      chk("rr.retry_ack",   {31'h0, bus.core_ack}, 32'h1);
      chk("rr.retry_rdata", bus.core_rdata,        32'h11111111);
      next_cycle();
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

      // Simultaneous loads from reset: core addr 5, loader addr 9.
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
`ifdef DMEM_ARB_RR_EN
      ec = 9'b100000100;
      el = 9'b000100000;
`else
      ec = 9'b000100100;
      el = 9'b100000000;
`endif
      for (int k = 0; k < 9; k++) begin
`ifdef DMEM_ARB_RR_EN
         cr_k = 1'b1;
         lr_k = (k <= 5);
`else
         cr_k = (k < 6);
         lr_k = 1'b1;
`endif
         drive(cr_k, 1'b0, 5'd5, 32'h0, lr_k, 1'b0, 5'd9, 32'h0);
         @(negedge clk);
         chk($sformatf("arb%0d.core_ack", k),   {31'h0, bus.core_ack},   {31'h0, ec[k]});
         chk($sformatf("arb%0d.ldr_ack", k),    {31'h0, bus.ldr_ack},    {31'h0, el[k]});
         chk($sformatf("arb%0d.core_rdata", k), bus.core_rdata,          ec[k] ? 32'h11111111 : 32'h0);
         chk($sformatf("arb%0d.ldr_rdata", k),  bus.ldr_rdata,           el[k] ? 32'h12345678 : 32'h0);
         chk($sformatf("arb%0d.core_stall", k), {31'h0, bus.core_stall}, {31'h0, cr_k & ~ec[k]});
         next_cycle();
      end
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port synchronous data RAM between the core's load/store path and an external loader/debug port. Each requester raises a request, holds it, and receives a one-cycle acknowledge, with read data on the same cycle as the acknowledge. A core stall output freezes the fetch/PC path while a core access is outstanding. The block sits between the DMI/register-file datapath and the data RAM.

## Interface
- ADDR_W, 5: word address width into the data RAM
- DATA_W, 32: data width
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- core_req  in  1  core access request; held until core_ack
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core store data
- core_ack  out  1  one-cycle pulse; transaction complete
- core_rdata  out  DATA_W  load data, valid only with core_ack
- core_stall  out  1  core_req & ~core_ack (combinational)
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_ack, ldr_rdata: loader port, same widths and rules as the core port
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req, pick a winner, latch its we/addr/wdata and index into owner register, go to ACCESS. Otherwise stay.
- ACCESS: drive mem_en=1, mem_we/addr/wdata from latched command. Write: pulse owner ack, go to IDLE. Read: go to RESP.
- RESP: pass mem_rdata to owner rdata, pulse owner ack, go to IDLE.
- Loser keeps its req high and is considered again on the next IDLE cycle.
- Command is latched in IDLE; requester changes to addr/wdata after that have no effect on the current transaction.
- A req dropped mid-transaction does not abort it; the ack still pulses and is ignored.
- Non-owner ack is always 0. Non-owner rdata is 0.
- Reset: state=IDLE, owner=core, last-grant=loader; every output 0 (core_stall follows core_req).
- Reset asserted in ACCESS or RESP: the transaction is dropped, no ack is issued, and mem_en=0 from the next cycle. A write that was already strobed stays in the RAM.

## Timing
- Request sampled in IDLE at edge t. mem_en high during cycle t+1.
- Write: ack during t+1. Read: ack and rdata during t+2.
- Back-to-back: one write per 2 cycles, one read per 3 cycles; there is a single IDLE cycle between transactions.
- core_stall is high from the first cycle of core_req until the ack cycle inclusive-exclusive: high before ack, low in the ack cycle.
- There is no combinational path from any req to mem_* outputs. All mem_* outputs are registered or driven from the FSM.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are active, the one not in last-grant wins, and last-grant updates on each grant.
- Not defined: fixed priority, with core always beating loader. The last-grant register is not built.

## Structure
- Package dmem_arb_pkg holds:
  - state typedef (IDLE/ACCESS/RESP)
  - port index constants PORT_CORE=0, PORT_LDR=1
- One sub-module, arb_pick2: a combinational 2-way picker taking req[1:0] and last-grant, and returning a one-hot grant. The macro selects its policy.

## Test plan
- Core store addr 3, data 0xDEADBEEF, loader idle: mem_en/mem_we high at t+1, core_ack at t+1; a subsequent load of addr 3 returns 0xDEADBEEF with core_ack at t+2.
- Core and loader request loads in the same cycle, with RR_EN defined and state from reset: core granted first and loader next. The loader ack arrives 3 cycles after the core ack. Without RR_EN, a continuously re-requesting core starves the loader.
- Loader store while core_req is asserted: core_stall stays 1 until core_ack. No ack appears on the wrong port, and core_rdata=0 outside its ack.
- Requester changes core_addr from 3 to 7 during ACCESS: mem_addr stays 3.
- rst pulsed during RESP of a load: no ack pulses, outputs 0 next cycle, and state IDLE. A held req is then re-served normally.
- Core drops core_req in ACCESS of a write: the write still lands in RAM and core_ack pulses once.
